nibble_serial_add_ctrl: RTL



---
 rtl/nibble_serial_add_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add/subtract controller that time-shares one external 4-bit
// ripple-carry adder, LSB nibble first, with a start/busy/done handshake.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sub,
  input  logic                 cin,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_cout,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 ovf
);

  localparam int IW = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  logic [NIBBLES-1:0][3:0] a_reg;
  logic [NIBBLES-1:0][3:0] b_reg;
  logic [NIBBLES-1:0][3:0] result_reg;
  logic [IW-1:0]           idx;
  logic                    carry_reg;
  logic                    last_ovf;

  assign result = result_reg;

  // The adder sees the current nibble only while running; it is parked at 0 otherwise.
  always_comb begin
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_reg[idx];
      add_b   = b_reg[idx];
      add_cin = carry_reg;
    end
  end

  // b_reg already holds ~B when subtracting, so one rule covers both modes.
  assign last_ovf = (a_reg[NIBBLES-1][3] == b_reg[NIBBLES-1][3]) &&
                    (add_sum[3] != a_reg[NIBBLES-1][3]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      idx        <= '0;
      carry_reg  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cout       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg      <= op_a;
            b_reg      <= sub ? ~op_b : op_b;
            carry_reg  <= sub ? 1'b1 : cin;
            idx        <= '0;
            result_reg <= '0;
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          result_reg[idx] <= add_sum;
          carry_reg       <= add_cout;
          if (idx == IW'(NIBBLES - 1)) begin
            cout  <= add_cout;
            ovf   <= last_ovf;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
